// File: rtl/cpu_pkg.sv
// Shared core types: redirect sources, scheduler states and address width.
// Imported by the PC redirect scheduler and its priority mux.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IRQ  = 2'd1,
        SRC_MRET = 2'd2,
        SRC_BR   = 2'd3
    } redirect_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } sched_state_e;

endpackage

// File: rtl/redirect_prio_mux.sv
// Fixed-priority redirect select: interrupt, then MRET, then branch.
// Returns the winning source and its target address.
module redirect_prio_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            irq_req,
    input  logic [XLEN-1:0] irq_vec,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mepc,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    output logic            win_valid,
    output redirect_src_e   win_src,
    output logic [XLEN-1:0] win_tgt
);

    // Highest-priority active request wins.
    always_comb begin
        win_valid = irq_req | mret_req | br_req;
        win_src   = SRC_NONE;
        win_tgt   = '0;
        if (irq_req) begin
            win_src = SRC_IRQ;
            win_tgt = irq_vec;
        end else if (mret_req) begin
            win_src = SRC_MRET;
            win_tgt = mepc;
        end else if (br_req) begin
            win_src = SRC_BR;
            win_tgt = br_target;
        end
    end

endmodule

// File: rtl/pc_redirect_sched.sv
// Next-PC scheduler: arbitrates redirects and parks one across fetch stalls.
// Optional saturating statistics counters under PC_REDIRECT_STATS_EN.
module pc_redirect_sched
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              STAT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_wait,
    input  logic            mem_wait,
    input  logic            wfi_mode,
    input  logic            irq_req,
    input  logic [XLEN-1:0] irq_vec,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mepc,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect_fire,
    output logic            pend_valid,
    output logic            irq_ack,
    output logic            pc_hold
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_irq,
    output logic [STAT_W-1:0] stat_mret,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    sched_state_e    state, state_d;
    redirect_src_e   pend_src, src_d;
    logic [XLEN-1:0] pend_tgt, tgt_d;
    redirect_src_e   fire_src;

    logic            win_valid;
    redirect_src_e   win_src;
    logic [XLEN-1:0] win_tgt;

    redirect_prio_mux #(.XLEN(XLEN)) u_prio (
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .mret_req  (mret_req),
        .mepc      (mepc),
        .br_req    (br_req),
        .br_target (br_target),
        .win_valid (win_valid),
        .win_src   (win_src),
        .win_tgt   (win_tgt)
    );

    // Scheduler state and parked redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pend_src <= SRC_NONE;
            pend_tgt <= '0;
        end else begin
            state    <= state_d;
            pend_src <= src_d;
            pend_tgt <= tgt_d;
        end
    end

    // Next-PC selection, parking and replay of redirects.
    always_comb begin
        state_d       = state;
        src_d         = pend_src;
        tgt_d         = pend_tgt;
        fire_src      = SRC_NONE;
        next_pc       = pc_cur + XLEN'(4);
        redirect_fire = 1'b0;
        pend_valid    = 1'b0;
        irq_ack       = 1'b0;
        pc_hold       = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
            next_pc = RESET_PC;
        end else if (state == ST_IDLE) begin
            irq_ack = irq_req;
            if (win_valid && !fetch_wait) begin
                next_pc       = win_tgt;
                redirect_fire = 1'b1;
                fire_src      = win_src;
            end else if (win_valid) begin
                state_d = ST_PEND;
                src_d   = win_src;
                tgt_d   = win_tgt;
                next_pc = pc_cur;
                pc_hold = 1'b1;
            end else if (fetch_wait || mem_wait || wfi_mode) begin
                next_pc = pc_cur;
                pc_hold = 1'b1;
            end
        end else begin
            pend_valid = 1'b1;
            irq_ack    = irq_req;
            if (fetch_wait) begin
                next_pc = pc_cur;
                pc_hold = 1'b1;
                if (irq_req) begin
                    src_d = SRC_IRQ;
                    tgt_d = irq_vec;
                end
            end else begin
                state_d       = ST_IDLE;
                src_d         = SRC_NONE;
                redirect_fire = 1'b1;
                if (irq_req) begin
                    next_pc  = irq_vec;
                    fire_src = SRC_IRQ;
                end else begin
                    next_pc  = pend_tgt;
                    fire_src = pend_src;
                end
            end
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    // Saturating per-source fire counters and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_irq   <= '0;
            stat_mret  <= '0;
            stat_br    <= '0;
            stat_stall <= '0;
        end else begin
            if (redirect_fire && fire_src == SRC_IRQ
                && stat_irq != '1)
                stat_irq <= stat_irq + 1'b1;
            if (redirect_fire && fire_src == SRC_MRET
                && stat_mret != '1)
                stat_mret <= stat_mret + 1'b1;
            if (redirect_fire && fire_src == SRC_BR
                && stat_br != '1)
                stat_br <= stat_br + 1'b1;
            if (pc_hold && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_sched.sv
// Self-checking bench for pc_redirect_sched: table vectors,
// directed stall/replay sequences and a random model comparison.
module tb_pc_redirect_sched;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_wait, mem_wait, wfi_mode;
    logic        irq_req, mret_req, br_req;
    logic [31:0] irq_vec, mepc, br_target, pc_cur;
    logic [31:0] next_pc;
    logic        redirect_fire, pend_valid, irq_ack, pc_hold;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] stat_irq, stat_mret, stat_br, stat_stall;
`endif

    int n_total = 0;
    int n_pass  = 0;

    pc_redirect_sched #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_wait    (fetch_wait),
        .mem_wait      (mem_wait),
        .wfi_mode      (wfi_mode),
        .irq_req       (irq_req),
        .irq_vec       (irq_vec),
        .mret_req      (mret_req),
        .mepc          (mepc),
        .br_req        (br_req),
        .br_target     (br_target),
        .pc_cur        (pc_cur),
        .next_pc       (next_pc),
        .redirect_fire (redirect_fire),
        .pend_valid    (pend_valid),
        .irq_ack       (irq_ack),
        .pc_hold       (pc_hold)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .stat_irq      (stat_irq),
        .stat_mret     (stat_mret),
        .stat_br       (stat_br),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic setin(input logic r, input logic fw, input logic mw,
                         input logic wf, input logic iq, input logic mr,
                         input logic br, input logic [31:0] pc);
        rst = r; fetch_wait = fw; mem_wait = mw; wfi_mode = wf;
        irq_req = iq; mret_req = mr; br_req = br; pc_cur = pc;
        #2;
    endtask

    task automatic expo(input string nm, input logic [31:0] npc,
                        input logic fire, input logic pv,
                        input logic ack, input logic hold);
        chk({nm, ".next_pc"}, next_pc, npc);
        chk({nm, ".fire"}, 32'(redirect_fire), 32'(fire));
        chk({nm, ".pend_valid"}, 32'(pend_valid), 32'(pv));
        chk({nm, ".irq_ack"}, 32'(irq_ack), 32'(ack));
        chk({nm, ".pc_hold"}, 32'(pc_hold), 32'(hold));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fw, mw, wf, iq, mr, br;
        logic [31:0] pc;
        logic [31:0] e_npc;
        logic        e_fire, e_ack, e_hold;
    } vec_t;

    vec_t tbl[10];

    // Reference model state: at most one parked redirect target.
    logic [31:0] q[$];

    initial begin
        logic [31:0] e_npc;
        logic        e_fire, e_pv, e_ack, e_hold, has;
        logic [31:0] w_tgt;
        logic [31:0] qn[$];

        irq_vec = 32'h8000; mepc = 32'h300; br_target = 32'h200;
        tbl[0] = '{0,0,0,0,0,0, 32'h0,        32'h4,   0,0,0};
        tbl[1] = '{0,0,0,0,0,1, 32'h40,       32'h200, 1,0,0};
        tbl[2] = '{0,0,0,1,1,1, 32'h40,       32'h8000,1,1,0};
        tbl[3] = '{0,0,0,0,1,1, 32'h40,       32'h300, 1,0,0};
        tbl[4] = '{0,0,1,0,0,0, 32'h100,      32'h100, 0,0,1};
        tbl[5] = '{0,1,0,0,0,0, 32'h104,      32'h104, 0,0,1};
        tbl[6] = '{1,0,0,0,0,0, 32'h108,      32'h108, 0,0,1};
        tbl[7] = '{0,0,0,0,0,0, 32'hFFFF_FFFC,32'h0,   0,0,0};
        tbl[8] = '{0,0,1,1,0,0, 32'h10,       32'h8000,1,1,0};
        tbl[9] = '{0,1,1,0,1,0, 32'h10,       32'h300, 1,0,0};

        // Reset state and first sequential step.
        #1;
        setin(1,0,0,0,0,0,0, 32'h1234);
        expo("reset", RPC, 0, 0, 0, 0);
        tick();
        setin(1,1,1,1,1,1,1, 32'h1234);
        expo("reset_req", RPC, 0, 0, 0, 0);
        tick();
        setin(0,0,0,0,0,0,0, 32'h0);
        expo("rel", 32'h4, 0, 0, 0, 0);
        tick();

        // Single-cycle vectors from IDLE.
        foreach (tbl[i]) begin
            setin(0, tbl[i].fw, tbl[i].mw, tbl[i].wf,
                  tbl[i].iq, tbl[i].mr, tbl[i].br, tbl[i].pc);
            expo($sformatf("tbl%0d", i), tbl[i].e_npc,
                 tbl[i].e_fire, 0, tbl[i].e_ack, tbl[i].e_hold);
            tick();
        end

        // Branch parked over a 5-cycle fetch stall.
        setin(0,1,0,0,0,0,1, 32'h50);
        expo("br_cap", 32'h50, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            setin(0,1,0,0,0,0,0, 32'h50);
            expo($sformatf("br_stall%0d", i), 32'h50, 0, 1, 0, 1);
            tick();
        end
        setin(0,0,0,0,0,0,0, 32'h50);
        expo("br_rel", 32'h200, 1, 1, 0, 0);
        tick();
        setin(0,0,0,0,0,0,0, 32'h200);
        expo("br_after", 32'h204, 0, 0, 0, 0);
        tick();

        // Interrupt pre-empts a parked branch during the stall.
        setin(0,1,0,0,0,0,1, 32'h60);
        expo("pre_cap", 32'h60, 0, 0, 0, 1);
        tick();
        setin(0,1,0,0,0,0,0, 32'h60);
        expo("pre_s1", 32'h60, 0, 1, 0, 1);
        tick();
        setin(0,1,0,0,1,0,0, 32'h60);
        expo("pre_irq", 32'h60, 0, 1, 1, 1);
        tick();
        setin(0,1,0,0,0,0,0, 32'h60);
        expo("pre_s3", 32'h60, 0, 1, 0, 1);
        tick();
        setin(0,0,1,1,0,0,0, 32'h60);
        expo("pre_rel", 32'h8000, 1, 1, 0, 0);
        tick();

        // Pending MRET ignores a later branch.
        setin(0,1,0,0,0,1,0, 32'h70);
        expo("mr_cap", 32'h70, 0, 0, 0, 1);
        tick();
        setin(0,1,0,0,0,0,1, 32'h70);
        expo("mr_br", 32'h70, 0, 1, 0, 1);
        tick();
        setin(0,0,0,0,0,0,1, 32'h70);
        expo("mr_rel", 32'h300, 1, 1, 0, 0);
        tick();

        // Release with a same-cycle interrupt fires the vector.
        setin(0,1,0,0,0,0,1, 32'h80);
        tick();
        setin(0,0,0,0,1,0,0, 32'h80);
        expo("rel_irq", 32'h8000, 1, 1, 1, 0);
        tick();

        // Reset while pending drops the entry.
        setin(0,1,0,0,0,0,1, 32'h90);
        tick();
        setin(1,1,0,0,0,0,0, 32'h90);
        expo("rst_pend", RPC, 0, 0, 0, 0);
        tick();
        setin(0,0,0,0,0,0,0, 32'h90);
        expo("rst_after", 32'h94, 0, 0, 0, 0);
        tick();

        // Random traffic against the queue model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            irq_vec   = $urandom & 32'hFFFF_FFFC;
            mepc      = $urandom & 32'hFFFF_FFFC;
            br_target = $urandom & 32'hFFFF_FFFC;
            setin($urandom_range(0, 40) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                              : ($urandom & ~32'h3));
            qn = q;
            e_npc = pc_cur + 32'd4;
            e_fire = 0; e_pv = 0; e_ack = 0; e_hold = 0;
            has = irq_req | mret_req | br_req;
            w_tgt = irq_req ? irq_vec : mret_req ? mepc : br_target;
            if (rst) begin
                e_npc = RPC;
                qn.delete();
            end else if (q.size() == 0) begin
                e_ack = irq_req;
                if (has && !fetch_wait) begin
                    e_npc = w_tgt; e_fire = 1;
                end else if (has) begin
                    e_npc = pc_cur; e_hold = 1;
                    qn.push_back(w_tgt);
                end else if (fetch_wait | mem_wait | wfi_mode) begin
                    e_npc = pc_cur; e_hold = 1;
                end
            end else begin
                e_pv = 1;
                e_ack = irq_req;
                if (fetch_wait) begin
                    e_npc = pc_cur; e_hold = 1;
                    if (irq_req) qn[0] = irq_vec;
                end else begin
                    e_fire = 1;
                    e_npc = irq_req ? irq_vec : q[0];
                    qn.delete();
                end
            end
            expo($sformatf("rnd%0d", c), e_npc, e_fire, e_pv,
                 e_ack, e_hold);
            tick();
            q = qn;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
